// File: rtl/atmos_light_est.sv
// atmos_light_est
//   Per-frame atmospheric-light estimator for the dark-channel-prior dehaze
//   pipeline. While a frame is active it builds a 256-bin histogram of the
//   dark channel and tracks the brightest source pixel whose dark value is at
//   or above the current threshold. In vertical blanking it scans the
//   histogram from the top bin down to find the next frame's threshold, then
//   publishes the new atmospheric light A.
//
//   Optional build macro: ATMOS_LUMA_EN
//     defined   : intensity = (77R + 150G + 29B) >> 8, one extra pipe stage,
//                 DRAIN lasts 3 cycles
//     undefined : intensity = max(R,G,B), DRAIN lasts 2 cycles
//
// Ports
//   clk              sole clock
//   rst              synchronous active-high reset (enters INIT)
//   per_frame_vsync  high for the whole active frame
//   per_frame_href   line valid
//   per_frame_clken  pixel strobe; pixel valid = href & clken
//   per_img[23:0]    source RGB {R,G,B}, aligned with per_dark
//   per_dark[7:0]    dark-channel value of the same pixel
//   post_A[7:0]      atmospheric light, held between updates
//   post_A_valid     one-cycle pulse when post_A is (re)published
//   busy             high in INIT, DRAIN, SCAN, UPDATE
//   overrun          one-cycle pulse when a frame start is skipped
module atmos_light_est #(
  parameter int unsigned          IMG_CNT_W = 20,
  parameter logic [IMG_CNT_W-1:0] TOP_NUM   = 20'd1000,
  parameter logic [7:0]           A_INIT    = 8'd200,
  parameter logic [7:0]           A_MAX     = 8'd230
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [23:0] per_img,
  input  logic [7:0]  per_dark,
  output logic [7:0]  post_A,
  output logic        post_A_valid,
  output logic        busy,
  output logic        overrun
);

`ifdef ATMOS_LUMA_EN
  localparam logic [7:0] DRAIN_LAST = 8'd2;
`else
  localparam logic [7:0] DRAIN_LAST = 8'd1;
`endif

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACCUM, S_DRAIN, S_SCAN, S_UPDATE} state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;   // INIT: bin up-counter, DRAIN: cycle count, SCAN: bin down-counter

  // ---------------- input register / edge detect ----------------
  logic        vsync_r, vsync_rr;
  logic        pix_vld_r;
  logic [7:0]  dark_r;
  logic [23:0] img_r;
  logic        rise, fall;

  assign rise = vsync_r & ~vsync_rr;
  assign fall = ~vsync_r & vsync_rr;

  // ---------------- histogram RAM (registered read) ----------------
  logic [IMG_CNT_W-1:0] hist [256];
  logic [IMG_CNT_W-1:0] rdata, wdata;
  logic [7:0]           raddr, waddr;
  logic                 we;

  always_ff @(posedge clk) begin
    if (we) hist[waddr] <= wdata;
    rdata <= hist[raddr];
  end

  // ---------------- RMW pipeline ----------------
  logic                 s0_vld, s1_vld;
  logic [7:0]           s1_addr;
  logic                 last_we;
  logic [7:0]           last_waddr;
  logic [IMG_CNT_W-1:0] last_wdata;
  logic [IMG_CNT_W-1:0] cur, cur_inc;

  assign s0_vld = pix_vld_r && (state_q == S_ACCUM);

  // A write landing on the same edge as the read returns the stale value;
  // the last write is kept one cycle so back-to-back hits see the pending count.
  assign cur     = (last_we && (last_waddr == s1_addr)) ? last_wdata : rdata;
  assign cur_inc = (&cur) ? cur : cur + IMG_CNT_W'(1);

  always_comb begin
    we    = s1_vld;
    waddr = s1_addr;
    wdata = cur_inc;
    raddr = dark_r;
    case (state_q)
      S_INIT: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
      end
      // Prime the read of bin 255 so SCAN sees one bin per cycle.
      S_DRAIN: raddr = 8'd255;
      S_SCAN: begin
        raddr = cnt_q - 8'd1;
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
      end
      default: ;
    endcase
  end

  // ---------------- intensity ----------------
  logic [7:0] inten;
  logic       iv_vld;
  logic [7:0] iv_dark, iv_int;

  always_comb begin
    inten = img_r[23:16];
    if (img_r[15:8] > inten) inten = img_r[15:8];
    if (img_r[7:0]  > inten) inten = img_r[7:0];
  end

`ifdef ATMOS_LUMA_EN
  logic [15:0] luma_sum;
  assign luma_sum = 16'd77  * {8'd0, img_r[23:16]}
                  + 16'd150 * {8'd0, img_r[15:8]}
                  + 16'd29  * {8'd0, img_r[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      iv_vld  <= 1'b0;
      iv_dark <= '0;
      iv_int  <= '0;
    end else begin
      iv_vld  <= s0_vld;
      iv_dark <= dark_r;
      iv_int  <= 8'(luma_sum >> 8);
    end
  end
`else
  assign iv_vld  = s0_vld;
  assign iv_dark = dark_r;
  assign iv_int  = inten;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) state_d = S_IDLE;
      end
      S_IDLE:  if (rise) state_d = S_ACCUM;
      S_ACCUM: if (fall) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_SCAN;
          cnt_d   = 8'd255;
        end
      end
      S_SCAN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  assign busy = (state_q == S_INIT) || (state_q == S_DRAIN) ||
                (state_q == S_SCAN) || (state_q == S_UPDATE);

  // ---------------- datapath ----------------
  logic [7:0]           thr, max_i, new_thr;
  logic                 hit, found;
  logic [IMG_CNT_W-1:0] acc, acc_sat;
  logic [IMG_CNT_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, rdata};
  assign acc_sat = acc_sum[IMG_CNT_W] ? '1 : acc_sum[IMG_CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_r      <= 1'b0;
      vsync_rr     <= 1'b0;
      pix_vld_r    <= 1'b0;
      dark_r       <= '0;
      img_r        <= '0;
      s1_vld       <= 1'b0;
      s1_addr      <= '0;
      last_we      <= 1'b0;
      last_waddr   <= '0;
      last_wdata   <= '0;
      thr          <= '0;
      max_i        <= '0;
      hit          <= 1'b0;
      acc          <= '0;
      found        <= 1'b0;
      new_thr      <= '0;
      post_A       <= A_INIT;
      post_A_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      vsync_r    <= per_frame_vsync;
      vsync_rr   <= vsync_r;
      pix_vld_r  <= per_frame_href & per_frame_clken;
      dark_r     <= per_dark;
      img_r      <= per_img;
      s1_vld     <= s0_vld;
      s1_addr    <= dark_r;
      last_we    <= we;
      last_waddr <= waddr;
      last_wdata <= wdata;

      post_A_valid <= (state_q == S_UPDATE);
      overrun      <= rise && (state_q != S_IDLE);

      if (state_q == S_UPDATE) begin
        if (hit) post_A <= (max_i > A_MAX) ? A_MAX : max_i;
        thr     <= new_thr;
        max_i   <= '0;
        hit     <= 1'b0;
        acc     <= '0;
        found   <= 1'b0;
        new_thr <= '0;
      end else begin
        if (iv_vld && (iv_dark >= thr) && (iv_int > max_i)) begin
          max_i <= iv_int;
          hit   <= 1'b1;
        end
        // First bin (from the top) where the running count reaches TOP_NUM.
        if (state_q == S_SCAN) begin
          acc <= acc_sat;
          if (!found && (acc_sat >= TOP_NUM)) begin
            found   <= 1'b1;
            new_thr <= cnt_q;
          end
        end
      end
    end
  end

endmodule
